pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter FPU_TIMEOUT, default 64: maximum cycles spent in WAIT (range 2..255).
REQ-002 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports rs1_ID, rs2_ID  in  5 each  source register indices of the instruction in ID.
REQ-005 SHALL have ports rs1_float_ID, rs2_float_ID  in  1 each  source register is in the float file.
REQ-006 SHALL have port rd_EX  in  5  destination index of the instruction in EX.
REQ-007 SHALL have port rd_float_EX  in  1  EX destination is in the float file.
REQ-008 SHALL have port load_EX  in  1  EX instruction is a load with regW enabled.
REQ-009 SHALL have port redirect_EX  in  1  taken branch or jump resolved in EX.
REQ-010 SHALL have port trap_flush  in  1  CSR/trap flush of the whole front end.
REQ-011 SHALL have port fpu_mc_EX  in  1  EX holds a multicycle FPU op (div/sqrt).
REQ-012 SHALL have port fpu_done  in  1  FPU result valid, single-cycle pulse.
REQ-013 SHALL have ports pc_en, en_IF_ID, en_ID_EX, en_EX_MEM  out  1 each  stage enables.
REQ-014 SHALL have ports flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  bubble insertion (NOP, 0x00000013).
REQ-015 SHALL have ports fpu_start, fpu_kill  out  1 each  one-cycle FPU command pulses.
REQ-016 SHALL have port fpu_timeout  out  1  sticky flag: WAIT exceeded FPU_TIMEOUT.

Function
REQ-017 SHALL implement FSM states IDLE, START, WAIT, DONE; the cycle counter is 8 bits.
REQ-018 IDLE: fpu_mc_EX=1 and trap_flush=0 and redirect_EX=0 -> START; otherwise remain in IDLE.
REQ-019 START: fpu_start=1 for exactly this cycle; counter cleared; -> WAIT; fpu_done is ignored in START.
REQ-020 WAIT: counter increments each cycle; fpu_done=1 -> DONE; counter reaches FPU_TIMEOUT-1 without done -> DONE and fpu_timeout set.
REQ-021 DONE: lasts one cycle with all enables 1 and no flushes, so EX_MEM captures the result; -> IDLE, and fpu_mc_EX is not re-evaluated in this cycle.
REQ-022 START/WAIT outputs: pc_en=0, en_IF_ID=0, en_ID_EX=0, en_EX_MEM=1, flush_EX_MEM=1 (bubble into MEM while EX holds).
REQ-023 Load-use stall (IDLE only) is raised when load_EX=1 and rdX matches with equal float class, where rdX is rs1_ID or rs2_ID and the float flags compare equal; integer rd_EX=0 never matches, float f0 does match.
REQ-024 Load-use stall response: pc_en=0, en_IF_ID=0, flush_ID_EX=1, en_ID_EX=1, en_EX_MEM=1; it lasts one cycle.
REQ-025 redirect_EX (IDLE): flush_IF_ID=1, flush_ID_EX=1, pc_en=1; it overrides load-use.
REQ-026 trap_flush in any state: all three flushes 1, all enables 1, FSM -> IDLE on the next edge.
REQ-027 trap_flush in START or WAIT additionally drives fpu_kill=1 for that cycle.
REQ-028 Priority: trap_flush > START/WAIT stall > redirect_EX > load-use > normal (all enables 1, flushes 0).
REQ-029 fpu_done arriving in IDLE or DONE SHALL be ignored.
REQ-030 fpu_timeout SHALL stay set until reset.

Reset
REQ-031 While rst=0: state=IDLE, counter=0, fpu_timeout=0, fpu_start=0, fpu_kill=0.
REQ-032 While rst=0: all enables=1 and all flushes=0, independent of the other inputs.
REQ-033 Reset asserted mid-WAIT SHALL abandon the op without driving fpu_kill; the FPU is reset by the same rst.

Configuration
REQ-034 The macro FPU_MULTICYCLE_EN SHALL control the multicycle FPU handling.
REQ-035 With FPU_MULTICYCLE_EN defined: the FSM, counter and fpu_* outputs behave as specified above.
REQ-036 Without FPU_MULTICYCLE_EN: FSM and counter are removed; fpu_start, fpu_kill and fpu_timeout are tied to 0; fpu_mc_EX and fpu_done are ignored; hazard and flush logic is unchanged.

Verification
REQ-037 Load-use: load_EX=1, rd_EX=5, rs2_ID=5, both float=0 -> one cycle of pc_en=0, en_IF_ID=0, flush_ID_EX=1. Repeat with rd_EX=0 -> no stall.
REQ-038 Float class: load_EX=1, rd_EX=3, rd_float_EX=1, rs1_ID=3, rs1_float_ID=0 -> no stall; with rs1_float_ID=1 -> stall.
REQ-039 Multicycle op: fpu_mc_EX=1 with fpu_done pulsed 10 cycles after START -> fpu_start is high for 1 cycle, front end stalled for 11 cycles, one DONE cycle, then IDLE.
REQ-040 Timeout: FPU_TIMEOUT=8, fpu_done never asserted -> DONE after 8 WAIT cycles and fpu_timeout=1 sticky.
REQ-041 Trap in WAIT: trap_flush=1 at WAIT cycle 3 -> fpu_kill=1 and all flushes=1 that cycle; IDLE on the next cycle.
REQ-042 Priority: redirect_EX=1 together with a load-use match -> flush_IF_ID=1, flush_ID_EX=1, pc_en=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard / flush controller.
// Handles load-use stalls, EX redirects, trap flushes and (optionally) the
// stall sequence around a multicycle FPU op held in EX.
// Optional feature macro: FPU_MULTICYCLE_EN -- when undefined the FPU
// sequencer is absent and fpu_start/fpu_kill/fpu_timeout read as 0.
module pipe_hazard_ctrl #(
    parameter int FPU_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       rs1_float_ID,
    input  logic       rs2_float_ID,
    input  logic [4:0] rd_EX,
    input  logic       rd_float_EX,
    input  logic       load_EX,
    input  logic       redirect_EX,
    input  logic       trap_flush,
    input  logic       fpu_mc_EX,
    input  logic       fpu_done,
    output logic       pc_en,
    output logic       en_IF_ID,
    output logic       en_ID_EX,
    output logic       en_EX_MEM,
    output logic       flush_IF_ID,
    output logic       flush_ID_EX,
    output logic       flush_EX_MEM,
    output logic       fpu_start,
    output logic       fpu_kill,
    output logic       fpu_timeout
);

    // ------------------------------------------------------------------
    // Load-use detection. Integer x0 is hard-wired zero so it never
    // creates a dependency; float f0 is a real register and does.
    // ------------------------------------------------------------------
    logic w_rd_valid;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;

    assign w_rd_valid = rd_float_EX || (rd_EX != 5'd0);
    assign w_rs1_hit  = (rs1_ID == rd_EX) && (rs1_float_ID == rd_float_EX);
    assign w_rs2_hit  = (rs2_ID == rd_EX) && (rs2_float_ID == rd_float_EX);
    assign w_load_use = load_EX && w_rd_valid && (w_rs1_hit || w_rs2_hit);

    // Sequencer status seen by the output logic.
    logic w_in_idle;    // normal hazard handling allowed
    logic w_in_start;   // first cycle of an FPU op: launch pulse
    logic w_fpu_busy;   // START or WAIT: front end frozen

`ifdef FPU_MULTICYCLE_EN

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Counter value on the last permitted WAIT cycle.
    localparam logic [7:0] CNT_LAST = 8'(FPU_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;

    // State, wait counter and sticky timeout flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state: launch on a multicycle op, wait for done or timeout,
    // one DONE cycle for EX_MEM capture; a trap returns to IDLE from anywhere.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (fpu_mc_EX && !redirect_EX)
                    w_state_nxt = S_START;
            end
            S_START: begin
                // Done is not possible yet; the FPU only just got the op.
                w_cnt_nxt   = 8'd0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (fpu_done) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = S_DONE;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_DONE: begin
                // fpu_mc_EX is still high for the finishing op; do not relaunch.
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (trap_flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
        end
    end

    assign w_in_idle   = (r_state == S_IDLE);
    assign w_in_start  = (r_state == S_START);
    assign w_fpu_busy  = (r_state == S_START) || (r_state == S_WAIT);
    assign fpu_timeout = r_timeout;

`else

    // No sequencer: the FPU handshake inputs are intentionally ignored.
    logic w_unused;
    assign w_unused    = fpu_mc_EX ^ fpu_done ^ (FPU_TIMEOUT == 0);

    assign w_in_idle   = 1'b1;
    assign w_in_start  = 1'b0;
    assign w_fpu_busy  = 1'b0;
    assign fpu_timeout = 1'b0;

`endif

    // Stage enables / flushes / FPU pulses by priority:
    // trap > FPU stall > redirect > load-use > normal; reset forces pass-through.
    always_comb begin
        pc_en        = 1'b1;
        en_IF_ID     = 1'b1;
        en_ID_EX     = 1'b1;
        en_EX_MEM    = 1'b1;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        fpu_start    = 1'b0;
        fpu_kill     = 1'b0;
        if (!rst) begin
            // Defaults already describe the reset view.
        end else if (trap_flush) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            fpu_kill     = w_fpu_busy;
        end else if (w_fpu_busy) begin
            // EX holds the op; bubbles go down into MEM meanwhile.
            pc_en        = 1'b0;
            en_IF_ID     = 1'b0;
            en_ID_EX     = 1'b0;
            flush_EX_MEM = 1'b1;
            fpu_start    = w_in_start;
        end else if (w_in_idle && redirect_EX) begin
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (w_in_idle && w_load_use) begin
            // Hold IF/ID one cycle, push a bubble into EX.
            pc_en       = 1'b0;
            en_IF_ID    = 1'b0;
            flush_ID_EX = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Two instances (timeout 64 and 8)
// share the inputs; a cycle-level reference model predicts every output.
module tb_pipe_hazard_ctrl;

`ifdef FPU_MULTICYCLE_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic       rs1_float_ID, rs2_float_ID, rd_float_EX;
    logic       load_EX, redirect_EX, trap_flush, fpu_mc_EX, fpu_done;

    logic [1:0] pc_en, en_IF_ID, en_ID_EX, en_EX_MEM;
    logic [1:0] flush_IF_ID, flush_ID_EX, flush_EX_MEM;
    logic [1:0] fpu_start, fpu_kill, fpu_timeout;

    pipe_hazard_ctrl #(.FPU_TIMEOUT(64)) u_dut64 (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_float_ID(rs1_float_ID), .rs2_float_ID(rs2_float_ID),
        .rd_EX(rd_EX), .rd_float_EX(rd_float_EX), .load_EX(load_EX),
        .redirect_EX(redirect_EX), .trap_flush(trap_flush),
        .fpu_mc_EX(fpu_mc_EX), .fpu_done(fpu_done),
        .pc_en(pc_en[0]), .en_IF_ID(en_IF_ID[0]), .en_ID_EX(en_ID_EX[0]),
        .en_EX_MEM(en_EX_MEM[0]), .flush_IF_ID(flush_IF_ID[0]),
        .flush_ID_EX(flush_ID_EX[0]), .flush_EX_MEM(flush_EX_MEM[0]),
        .fpu_start(fpu_start[0]), .fpu_kill(fpu_kill[0]),
        .fpu_timeout(fpu_timeout[0])
    );

    pipe_hazard_ctrl #(.FPU_TIMEOUT(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_float_ID(rs1_float_ID), .rs2_float_ID(rs2_float_ID),
        .rd_EX(rd_EX), .rd_float_EX(rd_float_EX), .load_EX(load_EX),
        .redirect_EX(redirect_EX), .trap_flush(trap_flush),
        .fpu_mc_EX(fpu_mc_EX), .fpu_done(fpu_done),
        .pc_en(pc_en[1]), .en_IF_ID(en_IF_ID[1]), .en_ID_EX(en_ID_EX[1]),
        .en_EX_MEM(en_EX_MEM[1]), .flush_IF_ID(flush_IF_ID[1]),
        .flush_ID_EX(flush_ID_EX[1]), .flush_EX_MEM(flush_EX_MEM[1]),
        .fpu_start(fpu_start[1]), .fpu_kill(fpu_kill[1]),
        .fpu_timeout(fpu_timeout[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: age of the FPU op in flight (-1 = none, 0 = launch
    // cycle, k = k-th wait cycle), a one-cycle completion marker, sticky flag.
    int age     [2];
    bit in_done [2];
    bit tmo     [2];

    // Activity counters for the directed FPU scenarios.
    int n_stall0, n_start0, n_wait8;

    function automatic int limit(int k);
        return (k == 0) ? 64 : 8;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            age[k] = -1; in_done[k] = 1'b0; tmo[k] = 1'b0;
        end
    endfunction

    function automatic bit lu_hit();
        bit m1, m2;
        m1 = (rs1_ID == rd_EX) && (rs1_float_ID == rd_float_EX);
        m2 = (rs2_ID == rd_EX) && (rs2_float_ID == rd_float_EX);
        return load_EX && (m1 || m2) && (rd_float_EX || rd_EX != 5'd0);
    endfunction

    // {pc_en,en_IF_ID,en_ID_EX,en_EX_MEM,flIF,flID,flEX,start,kill,timeout}
    function automatic logic [9:0] expv(int k);
        bit busy;
        busy = (age[k] >= 0);
        if (!rst)          return 10'b1111_000_00_0;
        if (trap_flush)    return {4'b1111, 3'b111, 1'b0, busy, tmo[k]};
        if (busy)          return {4'b0001, 3'b001, (age[k] == 0), 1'b0, tmo[k]};
        if (in_done[k])    return {4'b1111, 3'b000, 2'b00, tmo[k]};
        if (redirect_EX)   return {4'b1111, 3'b110, 2'b00, tmo[k]};
        if (lu_hit())      return {4'b0011, 3'b010, 2'b00, tmo[k]};
        return {4'b1111, 3'b000, 2'b00, tmo[k]};
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            if (trap_flush) begin
                age[k] = -1; in_done[k] = 1'b0;
            end else if (age[k] == 0) begin
                age[k] = 1;
            end else if (age[k] >= 1) begin
                if (fpu_done || age[k] == limit(k)) begin
                    if (!fpu_done) tmo[k] = 1'b1;
                    age[k] = -1; in_done[k] = 1'b1;
                end else begin
                    age[k] = age[k] + 1;
                end
            end else if (in_done[k]) begin
                in_done[k] = 1'b0;
            end else if (MC && fpu_mc_EX && !redirect_EX) begin
                age[k] = 0;
            end
        end
    endfunction

    task automatic check(string tag);
        logic [9:0] act, e;
        for (int k = 0; k < 2; k++) begin
            act = {pc_en[k], en_IF_ID[k], en_ID_EX[k], en_EX_MEM[k],
                   flush_IF_ID[k], flush_ID_EX[k], flush_EX_MEM[k],
                   fpu_start[k], fpu_kill[k], fpu_timeout[k]};
            e = expv(k);
            n_chk++;
            assert (act === e) else begin
                n_fail++;
                $error("FAIL %s dut%0d observed=%b expected=%b", tag, k, act, e);
            end
        end
    endtask

    task automatic check_int(string tag, int act, int e);
        n_chk++;
        assert (act === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, e);
        end
    endtask

    task automatic clear_in();
        rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
        rs1_float_ID = 1'b0; rs2_float_ID = 1'b0; rd_float_EX = 1'b0;
        load_EX = 1'b0; redirect_EX = 1'b0; trap_flush = 1'b0;
        fpu_mc_EX = 1'b0; fpu_done = 1'b0;
    endtask

    task automatic rand_in();
        rs1_ID       = 5'($urandom_range(3));
        rs2_ID       = 5'($urandom_range(3));
        rd_EX        = 5'($urandom_range(3));
        rs1_float_ID = 1'($urandom_range(1));
        rs2_float_ID = 1'($urandom_range(1));
        rd_float_EX  = 1'($urandom_range(1));
        load_EX      = 1'($urandom_range(1));
        redirect_EX  = ($urandom_range(7) == 0);
        trap_flush   = ($urandom_range(15) == 0);
        fpu_mc_EX    = ($urandom_range(3) == 0);
        fpu_done     = ($urandom_range(7) == 0);
    endtask

    // Inputs are applied just after a falling edge; check mid-low-phase,
    // then advance the model across the rising edge.
    task automatic tick(string tag);
        #2;
        check(tag);
        n_stall0 += (pc_en[0] == 1'b0) ? 1 : 0;
        n_start0 += (fpu_start[0] == 1'b1) ? 1 : 0;
        n_wait8  += (pc_en[1] == 1'b0 && fpu_start[1] == 1'b0) ? 1 : 0;
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
    endtask

    task automatic pulse_reset(string tag);
        rst = 1'b0;
        model_reset();
        #2;
        check(tag);
        @(negedge clk);
        rst = 1'b1;
        clear_in();
    endtask

    initial begin
        clear_in();
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        #2 check("reset_idle");
        rand_in();
        #1 check("reset_rand_inputs");
        @(negedge clk);
        clear_in();
        rst = 1'b1;

        // Integer load-use on rs2, then x0 which must not stall.
        load_EX = 1'b1; rd_EX = 5'd5; rs2_ID = 5'd5;
        tick("lu_int_rs2");
        clear_in();
        tick("lu_released");
        load_EX = 1'b1; rd_EX = 5'd0; rs2_ID = 5'd0;
        tick("lu_x0_nostall");

        // Register-class mismatch, then matching float x3 and f0.
        clear_in();
        load_EX = 1'b1; rd_EX = 5'd3; rd_float_EX = 1'b1; rs1_ID = 5'd3;
        tick("fclass_mismatch");
        rs1_float_ID = 1'b1;
        tick("fclass_f3_match");
        rd_EX = 5'd0; rs1_ID = 5'd0;
        tick("fclass_f0_match");

        // Redirect together with a load-use match.
        clear_in();
        load_EX = 1'b1; rd_EX = 5'd7; rs1_ID = 5'd7; redirect_EX = 1'b1;
        tick("redirect_over_lu");
        clear_in();
        tick("normal");

        // Multicycle op completing on the 10th cycle after START.
        fpu_mc_EX = 1'b1;
        tick("mc_detect");
        n_stall0 = 0; n_start0 = 0;
        for (int i = 0; i <= 10; i++) begin
            fpu_done = (i == 10);
            tick("mc_run");
        end
        fpu_done = 1'b0;
        tick("mc_done_cycle");
        fpu_mc_EX = 1'b0;
        tick("mc_back_idle");
        check_int("mc_stall_cycles", n_stall0, MC ? 11 : 0);
        check_int("mc_start_pulses", n_start0, MC ? 1 : 0);
        pulse_reset("rst_after_mc");

        // Timeout on the FPU_TIMEOUT=8 instance, done never arrives.
        fpu_mc_EX = 1'b1;
        tick("to_detect");
        tick("to_start");
        n_wait8 = 0;
        for (int i = 0; i < 8; i++) tick("to_wait");
        fpu_mc_EX = 1'b0;
        tick("to_done_cycle");
        check_int("to_wait_cycles", n_wait8, MC ? 8 : 0);
        check_int("to_flag_set", int'(fpu_timeout[1]), MC ? 1 : 0);
        for (int i = 0; i < 4; i++) tick("to_sticky");
        check_int("to_flag_sticky", int'(fpu_timeout[1]), MC ? 1 : 0);
        pulse_reset("rst_clears_timeout");

        // Trap on the third WAIT cycle.
        fpu_mc_EX = 1'b1;
        tick("trap_detect");
        tick("trap_start");
        tick("trap_w1");
        tick("trap_w2");
        trap_flush = 1'b1;
        tick("trap_in_wait");
        trap_flush = 1'b0; fpu_mc_EX = 1'b0;
        tick("trap_then_idle");

        // Reset in the middle of WAIT: no kill pulse.
        fpu_mc_EX = 1'b1;
        for (int i = 0; i < 4; i++) tick("rst_mid_pre");
        pulse_reset("rst_mid_wait");
        tick("rst_mid_after");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(63) == 0) begin
                rand_in();
                pulse_reset("rand_reset");
            end else begin
                rand_in();
                tick("random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
